clp_inst_scheduler: RTL and testbench

Sequences convolution-layer-processor (CLP) execution from an on-chip instruction memory. On a start pulse it fetches 64-bit instructions from base_addr. For each one it drives the instruction word plus a one-cycle clp_enable to the instruction decoder, pulses clp_start, then waits for clp_done. It sits between the host/top-level control and the decoder/CLP pair.

---
 rtl/clp_inst_scheduler.sv | 144 ++++++++++++++
 tb/tb_clp_inst_scheduler.sv | 241 ++++++++++++++++++++++++
 2 files changed

// File: rtl/clp_inst_scheduler.sv
// CLP instruction scheduler: fetches 64-bit instructions, issues them to the decoder/CLP and waits for completion.
// Optional RUN-phase watchdog is enabled by defining WATCHDOG_EN.
module clp_inst_scheduler #(
    parameter int         ADDR_W      = 10,
    parameter logic [6:0] HALT_OPCODE = 7'h7F
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [ADDR_W-1:0] base_addr,
    input  logic [ADDR_W-1:0] inst_count,
    output logic              inst_rd_en,
    output logic [ADDR_W-1:0] inst_rd_addr,
    input  logic [63:0]       inst_rd_data,
    output logic [63:0]       instruction,
    output logic              clp_enable,
    output logic              clp_start,
    input  logic              clp_done,
    output logic              busy,
    output logic              done,
    output logic [ADDR_W-1:0] cur_index,
    output logic              error
);

    typedef enum logic [2:0] {IDLE, FETCH, WAIT, ISSUE, KICK, RUN, FIN} state_t;

    state_t            state;
    logic [ADDR_W-1:0] base_q;
    logic [ADDR_W-1:0] count_q;
    logic [ADDR_W-1:0] index;
    logic [ADDR_W-1:0] next_index;
    logic              launch;

    assign next_index = index + 1'b1;

`ifdef WATCHDOG_EN
    logic [15:0] wd;
`else
    assign error = 1'b0;
`endif

    // Outputs are registered alongside the state they belong to.
    // An accepted start spends one IDLE cycle with busy high before the latched count is examined.
    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= IDLE;
            base_q       <= '0;
            count_q      <= '0;
            index        <= '0;
            launch       <= 1'b0;
            inst_rd_en   <= 1'b0;
            inst_rd_addr <= '0;
            instruction  <= '0;
            clp_enable   <= 1'b0;
            clp_start    <= 1'b0;
            busy         <= 1'b0;
            done         <= 1'b0;
            cur_index    <= '0;
`ifdef WATCHDOG_EN
            wd           <= '0;
            error        <= 1'b0;
`endif
        end else begin
            inst_rd_en <= 1'b0;
            clp_enable <= 1'b0;
            clp_start  <= 1'b0;
            done       <= 1'b0;
            case (state)
                IDLE: begin
                    if (launch) begin
                        launch <= 1'b0;
                        if (count_q == '0) begin
                            state <= FIN;
                            done  <= 1'b1;
                        end else begin
                            state        <= FETCH;
                            inst_rd_en   <= 1'b1;
                            inst_rd_addr <= base_q;
                        end
                    end else if (start) begin
                        launch    <= 1'b1;
                        busy      <= 1'b1;
                        base_q    <= base_addr;
                        count_q   <= inst_count;
                        index     <= '0;
                        cur_index <= '0;
                    end
                end
                FETCH: state <= WAIT;
                WAIT: begin
                    instruction <= inst_rd_data;
                    if (inst_rd_data[63:57] == HALT_OPCODE) begin
                        state <= FIN;
                        done  <= 1'b1;
                    end else begin
                        state      <= ISSUE;
                        clp_enable <= 1'b1;
                    end
                end
                ISSUE: begin
                    state     <= KICK;
                    clp_start <= 1'b1;
                end
                KICK: begin
                    state <= RUN;
`ifdef WATCHDOG_EN
                    wd    <= instruction[22:7];
`endif
                end
                RUN: begin
                    if (clp_done) begin
                        index     <= next_index;
                        cur_index <= next_index;
                        if (next_index == count_q) begin
                            state <= FIN;
                            done  <= 1'b1;
                        end else begin
                            state        <= FETCH;
                            inst_rd_en   <= 1'b1;
                            inst_rd_addr <= base_q + next_index;
                        end
                    end
`ifdef WATCHDOG_EN
                    // A loaded value of 0 never counts, which disables the watchdog.
                    else if (wd != '0) begin
                        wd <= wd - 1'b1;
                        if (wd == 16'd1) begin
                            error <= 1'b1;
                            state <= FIN;
                            done  <= 1'b1;
                        end
                    end
`endif
                end
                FIN: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_clp_inst_scheduler.sv
// Directed bench for clp_inst_scheduler with a memory model and a CLP model of configurable latency.
module tb_clp_inst_scheduler;
    localparam int AW = 10;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          start = 1'b0;
    logic [AW-1:0] base_addr = '0;
    logic [AW-1:0] inst_count = '0;
    logic          inst_rd_en;
    logic [AW-1:0] inst_rd_addr;
    logic [63:0]   inst_rd_data = '0;
    logic [63:0]   instruction;
    logic          clp_enable;
    logic          clp_start;
    logic          clp_done;
    logic          busy;
    logic          done;
    logic [AW-1:0] cur_index;
    logic          error;

    clp_inst_scheduler #(.ADDR_W(AW), .HALT_OPCODE(7'h7F)) dut (
        .clk(clk), .rst(rst), .start(start), .base_addr(base_addr), .inst_count(inst_count),
        .inst_rd_en(inst_rd_en), .inst_rd_addr(inst_rd_addr), .inst_rd_data(inst_rd_data),
        .instruction(instruction), .clp_enable(clp_enable), .clp_start(clp_start),
        .clp_done(clp_done), .busy(busy), .done(done), .cur_index(cur_index), .error(error)
    );

    always #5 clk = ~clk;

    int          cyc = 0;
    logic [63:0] mem [0:1023];
    int          clp_delay = 10;
    logic        clp_done_on = 1'b1;
    logic [7:0]  clp_cnt = '0;

    always @(posedge clk) cyc <= cyc + 1;
    always @(posedge clk) if (inst_rd_en) inst_rd_data <= mem[inst_rd_addr];
    always @(posedge clk) begin
        if (clp_start) clp_cnt <= 8'(clp_delay);
        else if (clp_cnt != 0) clp_cnt <= clp_cnt - 1'b1;
    end
    assign clp_done = clp_done_on && (clp_cnt == 8'd1);

    // Event log, sampled on the falling edge.
    int          addr_q[$];
    int          rd_cyc[$];
    logic [63:0] en_words[$];
    int          en_cyc[$];
    int          n_done;
    int          done_cyc;

    always @(negedge clk) begin
        if (inst_rd_en) begin
            addr_q.push_back(int'(inst_rd_addr));
            rd_cyc.push_back(cyc);
        end
        if (clp_enable) begin
            en_words.push_back(instruction);
            en_cyc.push_back(cyc);
        end
        if (done) begin
            n_done   = n_done + 1;
            done_cyc = cyc;
        end
    end

    int checks = 0;
    int errors = 0;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    task automatic clear_log();
        addr_q.delete(); rd_cyc.delete(); en_words.delete(); en_cyc.delete();
        n_done = 0; done_cyc = 0;
    endtask

    task automatic pulse_start(input int b, input int n, output int t);
        tick();
        start = 1'b1; base_addr = AW'(b); inst_count = AW'(n); t = cyc;
        tick();
        start = 1'b0;
    endtask

    task automatic wait_done(input string tag);
        int k;
        for (k = 0; k < 600; k++) begin
            if (n_done > 0) break;
            tick();
        end
        chk({tag, "_timeout"}, 64'(k < 600), 64'd1);
        repeat (3) tick();
    endtask

    task automatic chk_idle_outputs(input string tag);
        chk({tag, "_busy"}, 64'(busy), 64'd0);
        chk({tag, "_en"}, 64'(clp_enable | clp_start | inst_rd_en | done), 64'd0);
        chk({tag, "_instr"}, instruction, 64'd0);
        chk({tag, "_addr"}, 64'(inst_rd_addr), 64'd0);
        chk({tag, "_idx"}, 64'(cur_index), 64'd0);
    endtask

    int t0;

    initial begin
        for (int i = 0; i < 1024; i++) mem[i] = '0;
        mem[5]    = 64'h0400_0000_0000_0011;
        mem[6]    = 64'h0800_1111_0000_0022;
        mem[7]    = 64'h0C00_2222_0000_0033;
        mem[1023] = 64'h1000_ABCD_0000_0044;
        mem[0]    = 64'h1400_1234_0000_0055;
        mem[100]  = 64'h1800_0000_0000_0066;
        mem[101]  = 64'hFE00_0000_0000_0077;
        mem[102]  = 64'h1C00_0000_0000_0001;
        mem[300]  = 64'h2000_0000_0000_0A00;

        repeat (3) tick();
        chk_idle_outputs("reset");
        chk("reset_error", 64'(error), 64'd0);
        rst = 1'b0;
        clear_log();

        // Test 1: three instructions from base 5.
        pulse_start(5, 3, t0);
        wait_done("t1");
        chk("t1_nrd", 64'(addr_q.size()), 64'd3);
        if (addr_q.size() == 3) begin
            chk("t1_a0", 64'(addr_q[0]), 64'd5);
            chk("t1_a1", 64'(addr_q[1]), 64'd6);
            chk("t1_a2", 64'(addr_q[2]), 64'd7);
        end
        chk("t1_nen", 64'(en_words.size()), 64'd3);
        if (en_words.size() == 3) begin
            chk("t1_w0", en_words[0], mem[5]);
            chk("t1_w1", en_words[1], mem[6]);
            chk("t1_w2", en_words[2], mem[7]);
            chk("t1_lat_first", 64'(en_cyc[0] - t0), 64'd4);
            chk("t1_lat_next", 64'(en_cyc[1] - en_cyc[0]), 64'd14);
        end
        chk("t1_ndone", 64'(n_done), 64'd1);
        chk("t1_busy", 64'(busy), 64'd0);
        chk("t1_error", 64'(error), 64'd0);

        // Test 2: zero-length program.
        clear_log();
        pulse_start(40, 0, t0);
        wait_done("t2");
        chk("t2_nrd", 64'(addr_q.size()), 64'd0);
        chk("t2_nen", 64'(en_words.size()), 64'd0);
        chk("t2_lat", 64'(done_cyc - t0), 64'd2);
        chk("t2_ndone", 64'(n_done), 64'd1);

        // Test 3: address wraps past the top of memory.
        clear_log();
        pulse_start(1023, 2, t0);
        wait_done("t3");
        chk("t3_nrd", 64'(addr_q.size()), 64'd2);
        if (addr_q.size() == 2) begin
            chk("t3_a0", 64'(addr_q[0]), 64'd1023);
            chk("t3_a1", 64'(addr_q[1]), 64'd0);
        end
        if (en_words.size() == 2) chk("t3_w1", en_words[1], mem[0]);

        // Test 4: halt opcode in the second word.
        clear_log();
        pulse_start(100, 4, t0);
        wait_done("t4");
        chk("t4_nen", 64'(en_words.size()), 64'd1);
        chk("t4_nrd", 64'(addr_q.size()), 64'd2);
        if (rd_cyc.size() == 2) chk("t4_done_lat", 64'(done_cyc - rd_cyc[1]), 64'd2);
        chk("t4_idx", 64'(cur_index), 64'd1);
        chk("t4_instr", instruction, mem[101]);
        chk("t4_ndone", 64'(n_done), 64'd1);

        // Test 5: reset during RUN aborts silently; a new run ignores a second start.
        clear_log();
        clp_delay = 50;
        pulse_start(5, 3, t0);
        for (int k = 0; k < 20 && en_words.size() == 0; k++) tick();
        repeat (5) tick();
        rst = 1'b1;
        tick();
        chk_idle_outputs("t5_rst");
        rst = 1'b0;
        repeat (60) tick();
        chk("t5_no_done", 64'(n_done), 64'd0);
        clear_log();
        clp_delay = 10;
        pulse_start(0, 1, t0);
        repeat (3) tick();
        start = 1'b1; base_addr = AW'(500); inst_count = AW'(5);
        tick();
        start = 1'b0;
        wait_done("t5");
        chk("t5_nrd", 64'(addr_q.size()), 64'd1);
        if (addr_q.size() == 1) chk("t5_a0", 64'(addr_q[0]), 64'd0);
        chk("t5_ndone", 64'(n_done), 64'd1);
        repeat (5) tick();
        chk("t5_ndone_after", 64'(n_done), 64'd1);
        chk("t5_busy", 64'(busy), 64'd0);

`ifdef WATCHDOG_EN
        // Test 6: watchdog with work_time 20.
        clear_log();
        clp_done_on = 1'b0;
        pulse_start(300, 1, t0);
        wait_done("t6a");
        chk("t6a_error", 64'(error), 64'd1);
        chk("t6a_ndone", 64'(n_done), 64'd1);
        if (en_cyc.size() == 1) chk("t6a_lat", 64'(done_cyc - en_cyc[0]), 64'd22);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("t6_rst_error", 64'(error), 64'd0);
        clear_log();
        clp_done_on = 1'b1;
        clp_delay = 20;
        pulse_start(300, 1, t0);
        wait_done("t6b");
        chk("t6b_error", 64'(error), 64'd0);
        chk("t6b_ndone", 64'(n_done), 64'd1);
        if (en_cyc.size() == 1) chk("t6b_lat", 64'(done_cyc - en_cyc[0]), 64'd22);
`else
        chk("no_wd_error", 64'(error), 64'd0);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
